// File: rtl/inpinf_mc.sv
// inpinf_mc: frame-gated multi-channel pixel input FIFO with read-side position tracking.
module inpinf_mc #(
    parameter int XB    = 10,
    parameter int YB    = 10,
    parameter int PB    = 8,
    parameter int NCH   = 3,
    parameter int DEPTH = 8,
    parameter int LB    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB-1:0]     cfg_width,
    input  logic [YB-1:0]     cfg_height,
    input  logic              frame_start,
    input  logic [NCH*PB-1:0] px_in_data,
    input  logic              px_in_valid,
    output logic              px_in_ready,
    input  logic              inf_rd,
    output logic              inf_valid,
    output logic [NCH*PB-1:0] inf_data,
    output logic [XB-1:0]     col_count,
    output logic [YB-1:0]     row_count,
    output logic              inc_mem_ptr,
    output logic              eof,
    output logic              busy,
    output logic [LB-1:0]     fifo_level,
    output logic [1:0]        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LB-1:0]     level_q, level_d;
    logic [XB-1:0]     wcol_q, wcol_d, col_q, col_d, cfg_w_q, cfg_w_d;
    logic [YB-1:0]     wrow_q, wrow_d, row_q, row_d, cfg_h_q, cfg_h_d;
    logic [1:0]        err_q, err_d;
    logic [NCH*PB-1:0] mem_q [DEPTH];
    logic push, pop, start_ok, start_bad, wlast_col, wlast;
    assign px_in_ready = state_q == ACTIVE && level_q != LB'(DEPTH);
    assign inf_valid   = level_q != '0;
    assign inf_data    = inf_valid ? mem_q[rptr_q] : '0;
    assign push        = px_in_valid & px_in_ready;
    assign pop         = inf_rd & inf_valid;
    assign start_ok    = state_q == IDLE && frame_start && cfg_width != '0 && cfg_height != '0;
    assign start_bad   = state_q == IDLE && frame_start && (cfg_width == '0 || cfg_height == '0);
    assign wlast_col   = wcol_q == cfg_w_q - XB'(1);
    assign wlast       = wlast_col && wrow_q == cfg_h_q - YB'(1);
    assign inc_mem_ptr = pop && col_q == cfg_w_q - XB'(1);
    assign eof         = inc_mem_ptr && row_q == cfg_h_q - YB'(1);
    assign col_count   = col_q;
    assign row_count   = row_q;
    assign busy        = state_q != IDLE;
    assign fifo_level  = level_q;
    assign err         = err_q;
    always_comb begin
        state_d = state_q;
        if (start_ok)
            state_d = ACTIVE;
        else if (state_q == ACTIVE && push && wlast)
            state_d = DRAIN;
        else if (state_q == DRAIN && eof)
            state_d = IDLE;
        cfg_w_d = start_ok ? cfg_width : cfg_w_q;
        cfg_h_d = start_ok ? cfg_height : cfg_h_q;
        wcol_d  = start_ok ? '0 : push ? (wlast_col ? '0 : wcol_q + XB'(1)) : wcol_q;
        wrow_d  = start_ok ? '0 : (push && wlast_col) ? (wlast ? '0 : wrow_q + YB'(1)) : wrow_q;
        col_d   = start_ok ? '0 : pop ? (inc_mem_ptr ? '0 : col_q + XB'(1)) : col_q;
        row_d   = start_ok ? '0 : inc_mem_ptr ? (eof ? '0 : row_q + YB'(1)) : row_q;
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + LB'(push) - LB'(pop);
        // A pop against an empty FIFO only flags; it never moves any pointer or counter.
        err_d   = (start_ok ? 2'b00 : err_q) | {inf_rd & ~inf_valid, start_bad};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            wcol_q  <= '0;
            wrow_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cfg_w_q <= '0;
            cfg_h_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            wcol_q  <= wcol_d;
            wrow_q  <= wrow_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cfg_w_q <= cfg_w_d;
            cfg_h_q <= cfg_h_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= px_in_data;
    end
endmodule

// File: tb/tb_inpinf_mc.sv
// tb_inpinf_mc: directed scenario checks for inpinf_mc (NCH=3, DEPTH=8).
module tb_inpinf_mc;
    logic        clk = 0, rst = 0;
    logic [9:0]  cfg_width = 0;
    logic [9:0]  cfg_height = 0;
    logic        frame_start = 0;
    logic [23:0] px_in_data = 0;
    logic        px_in_valid = 0, inf_rd = 0;
    logic        px_in_ready, inf_valid, inc_mem_ptr, eof, busy;
    logic [23:0] inf_data;
    logic [9:0]  col_count, row_count;
    logic [3:0]  fifo_level;
    logic [1:0]  err;
    int checks = 0, errors = 0;

    inpinf_mc dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .frame_start(frame_start), .px_in_data(px_in_data), .px_in_valid(px_in_valid),
        .px_in_ready(px_in_ready), .inf_rd(inf_rd), .inf_valid(inf_valid), .inf_data(inf_data),
        .col_count(col_count), .row_count(row_count), .inc_mem_ptr(inc_mem_ptr), .eof(eof),
        .busy(busy), .fifo_level(fifo_level), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] beat(input int k);
        return {8'(k + 64), 8'(k + 32), 8'(k)};
    endfunction

    task automatic do_reset;
        rst = 1; frame_start = 0; px_in_valid = 0; inf_rd = 0; px_in_data = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_width = 10'(w); cfg_height = 10'(h); frame_start = 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++; if (px_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0h want 0", px_in_ready); end
        checks++; if (inf_valid !== 1'b0) begin errors++; $display("FAIL rst_inf_valid: got %0h want 0", inf_valid); end
        checks++; if (inf_data !== 24'h0) begin errors++; $display("FAIL rst_inf_data: got %0h want 0", inf_data); end
        checks++; if ({col_count, row_count} !== 20'h0) begin errors++; $display("FAIL rst_counters: got %0h/%0h want 0/0", col_count, row_count); end
        checks++; if ({inc_mem_ptr, eof, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {inc_mem_ptr, eof, busy}); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", err); end
    endtask

    task automatic test_stream_frame;
        logic [23:0] q[$];
        int pushes, pops, dbad;
        logic [7:0] incm, eofm;
        bit done;
        do_reset;
        start_frame(4, 2);
        pushes = 0; pops = 0; dbad = 0; incm = 0; eofm = 0; done = 0;
        px_in_valid = 1; inf_rd = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            px_in_data = beat(pushes);
            #1;
            if (inf_valid && inf_rd) begin
                if (q.size() == 0 || inf_data !== q[0]) dbad++;
                if (q.size() != 0) void'(q.pop_front());
                pops++;
                if (pops <= 8) begin
                    incm[pops-1] = inc_mem_ptr;
                    eofm[pops-1] = eof;
                end else dbad++;
                if (eof) done = 1;
            end else if (inc_mem_ptr || eof) dbad++;
            if (px_in_ready && px_in_valid) begin
                q.push_back(px_in_data);
                pushes++;
            end
            @(negedge clk);
        end
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_eof_seen: got %0d want 1", done); end
        checks++; if (pushes != 8) begin errors++; $display("FAIL t1_pushes: got %0d want 8", pushes); end
        checks++; if (pops != 8) begin errors++; $display("FAIL t1_pops: got %0d want 8", pops); end
        checks++; if (incm !== 8'h88) begin errors++; $display("FAIL t1_inc_pops: got %b want 10001000", incm); end
        checks++; if (eofm !== 8'h80) begin errors++; $display("FAIL t1_eof_pops: got %b want 10000000", eofm); end
        checks++; if (dbad != 0) begin errors++; $display("FAIL t1_data: got %0d bad pops want 0", dbad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after_eof: got %0h want 0", busy); end
        checks++; if (px_in_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_after: got %0h want 0", px_in_ready); end
        checks++; if ({col_count, row_count} !== 20'h0) begin errors++; $display("FAIL t1_counters: got %0d/%0d want 0/0", col_count, row_count); end
        px_in_valid = 0; inf_rd = 0;
    endtask

    task automatic test_full;
        int acc;
        do_reset;
        start_frame(8, 4);
        acc = 0; px_in_valid = 1; inf_rd = 0;
        for (int c = 0; c < 10; c++) begin
            px_in_data = beat(acc);
            #1;
            if (px_in_ready) acc++;
            @(negedge clk);
        end
        #1;
        checks++; if (acc != 8) begin errors++; $display("FAIL t2_accepted: got %0d want 8", acc); end
        checks++; if (px_in_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_full: got %0h want 0", px_in_ready); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL t2_level_full: got %0d want 8", fifo_level); end
        px_in_valid = 0; inf_rd = 1;
        #1;
        checks++; if (inf_data !== beat(0)) begin errors++; $display("FAIL t2_head: got %0h want %0h", inf_data, beat(0)); end
        @(negedge clk);
        px_in_valid = 1; px_in_data = beat(8);
        #1;
        checks++; if (px_in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after_pop: got %0h want 1", px_in_ready); end
        @(negedge clk);
        inf_rd = 0;
        #1;
        checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL t2_level_pushpop: got %0d want 7", fifo_level); end
        checks++; if (col_count !== 10'd2) begin errors++; $display("FAIL t2_col: got %0d want 2", col_count); end
        checks++; if (inf_data !== beat(2)) begin errors++; $display("FAIL t2_head2: got %0h want %0h", inf_data, beat(2)); end
        px_in_data = beat(9);
        @(negedge clk);
        px_in_valid = 0;
        #1;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL t2_level_refill: got %0d want 8", fifo_level); end
    endtask

    task automatic test_cfg_error;
        do_reset;
        start_frame(0, 2);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy: got %0h want 0", busy); end
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL t3_err: got %b want 01", err); end
        checks++; if (px_in_ready !== 1'b0) begin errors++; $display("FAIL t3_ready: got %0h want 0", px_in_ready); end
        start_frame(2, 1);
        #1;
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL t3_err_clear: got %b want 00", err); end
        checks++; if ({busy, px_in_ready} !== 2'b11) begin errors++; $display("FAIL t3_active: got %b want 11", {busy, px_in_ready}); end
    endtask

    task automatic test_empty_pop_and_restart;
        do_reset;
        start_frame(2, 2);
        inf_rd = 1;
        @(negedge clk);
        inf_rd = 0;
        #1;
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL t4_err: got %b want 10", err); end
        checks++; if ({col_count, row_count, fifo_level} !== 24'h0) begin errors++; $display("FAIL t4_unchanged: got %0d/%0d/%0d want 0/0/0", col_count, row_count, fifo_level); end
        start_frame(5, 5);
        #1;
        checks++; if ({busy, err} !== 3'b110) begin errors++; $display("FAIL t4_restart_ignored: got %b want 110", {busy, err}); end
        px_in_valid = 1; px_in_data = beat(0);
        @(negedge clk);
        px_in_data = beat(1);
        @(negedge clk);
        px_in_valid = 0; inf_rd = 1;
        #1;
        checks++; if (inc_mem_ptr !== 1'b0) begin errors++; $display("FAIL t4_inc_pop1: got %0h want 0", inc_mem_ptr); end
        @(negedge clk);
        #1;
        checks++; if ({inc_mem_ptr, eof} !== 2'b10) begin errors++; $display("FAIL t4_inc_pop2: got %b want 10", {inc_mem_ptr, eof}); end
        @(negedge clk);
        inf_rd = 0;
        #1;
        checks++; if ({col_count, row_count} !== {10'd0, 10'd1}) begin errors++; $display("FAIL t4_pos: got %0d/%0d want 0/1", col_count, row_count); end
    endtask

    task automatic test_one_pixel;
        do_reset;
        start_frame(1, 1);
        px_in_valid = 1; px_in_data = beat(5);
        @(negedge clk);
        px_in_valid = 0;
        #1;
        checks++; if ({px_in_ready, inf_valid} !== 2'b01) begin errors++; $display("FAIL t5_drain: got %b want 01", {px_in_ready, inf_valid}); end
        checks++; if (inf_data !== beat(5)) begin errors++; $display("FAIL t5_data: got %0h want %0h", inf_data, beat(5)); end
        inf_rd = 1;
        #1;
        checks++; if ({inc_mem_ptr, eof} !== 2'b11) begin errors++; $display("FAIL t5_inc_eof: got %b want 11", {inc_mem_ptr, eof}); end
        @(negedge clk);
        inf_rd = 0;
        #1;
        checks++; if ({busy, fifo_level} !== 5'd0) begin errors++; $display("FAIL t5_idle: got %0h/%0d want 0/0", busy, fifo_level); end
    endtask

    task automatic test_async_reset;
        do_reset;
        start_frame(8, 2);
        px_in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            px_in_data = beat(i);
            @(negedge clk);
        end
        px_in_valid = 0; inf_rd = 1;
        @(negedge clk);
        inf_rd = 0;
        #1;
        checks++; if ({fifo_level, col_count} !== {4'd3, 10'd1}) begin errors++; $display("FAIL t6_pre: got %0d/%0d want 3/1", fifo_level, col_count); end
        rst = 1;
        #1;
        checks++; if ({fifo_level, px_in_ready, busy, inf_valid} !== 7'd0) begin errors++; $display("FAIL t6_flush: got %0d/%0h/%0h/%0h want 0/0/0/0", fifo_level, px_in_ready, busy, inf_valid); end
        checks++; if ({col_count, row_count} !== 20'h0) begin errors++; $display("FAIL t6_counters: got %0d/%0d want 0/0", col_count, row_count); end
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset;
        test_stream_frame;
        test_full;
        test_cfg_error;
        test_empty_pop_and_restart;
        test_one_pixel;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
